// File: rtl/fpu_pkg.sv
// Shared constants and types for the sequential floating-point adder.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
// Word format: exp[31:24] is 8-bit two's complement, mant[23:0] is unsigned.
package fpu_pkg;

  localparam int EXP_W  = 8;
  localparam int MANT_W = 24;
  localparam int WORD_W = EXP_W + MANT_W;

  typedef struct packed {
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } fp_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CMP   = 3'd1,
    S_ALIGN = 3'd2,
    S_ADD   = 3'd3,
    S_NORM  = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  // Result returned when the exponent increment would pass +127.
  localparam logic [WORD_W-1:0] SAT_POS = 32'h7FFF_FFFF;

  // Sign-extend an exponent onto the full width of the shared adder.
  function automatic logic [31:0] sext_exp(input logic [EXP_W-1:0] e);
    return {{(32-EXP_W){e[EXP_W-1]}}, e};
  endfunction

endpackage

// File: rtl/fpu_shared_add32.sv
// Single 32-bit adder shared by every arithmetic step of the sequencer.
// Latency: combinational.
// Backpressure: none; operands are selected by the caller's state.
// Ports: a, b (32) addends; cin carry-in; sum (32); cout carry-out.
module fpu_shared_add32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {32'd0, cin};

endmodule

// File: rtl/fpu_add_seq.sv
// Multi-cycle floating-point add: compare, align, add, renormalise on one adder.
// Latency: res_valid rises 4 clk edges after the accept edge; 1 op per 6 cycles.
// Backpressure: in_ready only in IDLE; DONE holds res/res_ovf until res_ready.
// Ports: clk, reset_n (async, active-low); in_valid/in_ready with op_a/op_b (32);
//        res_valid/res_ready with res (32) and res_ovf (saturated); busy.
module fpu_add_seq
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res,
  output logic        res_ovf,
  output logic        busy
);

  state_e              state_q, state_d;
  fp_t                 opa_q, opa_d, opb_q, opb_d;
  fp_t                 larger_q, larger_d;
  logic [MANT_W-1:0]   smaller_mant_q, smaller_mant_d;
  logic [EXP_W:0]      diff_q, diff_d;
  logic [MANT_W-1:0]   shifted_q, shifted_d;
  logic [MANT_W:0]     sum25_q, sum25_d;
  logic [WORD_W-1:0]   res_q, res_d;
  logic                res_ovf_q, res_ovf_d;

  logic [31:0] add_a, add_b, add_sum;
  logic        add_cin, add_cout;

  fpu_shared_add32 u_add (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Upper sum bits and carry-out never matter: every operation fits in 25 bits.
  logic unused_add;
  assign unused_add = ^{add_cout, add_sum[31:MANT_W+1]};

  // Adder operand mux, one-hot by state; subtraction is invert plus carry-in.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    unique case (state_q)
      S_CMP: begin
        add_a   = sext_exp(opa_q.exp);
        add_b   = ~sext_exp(opb_q.exp);
        add_cin = 1'b1;
      end
      S_ADD: begin
        add_a = {{(32-MANT_W){1'b0}}, larger_q.mant};
        add_b = {{(32-MANT_W){1'b0}}, shifted_q};
      end
      S_NORM: begin
        add_a = sext_exp(larger_q.exp);
        add_b = 32'd1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    opa_d          = opa_q;
    opb_d          = opb_q;
    larger_d       = larger_q;
    smaller_mant_d = smaller_mant_q;
    diff_d         = diff_q;
    shifted_d      = shifted_q;
    sum25_d        = sum25_q;
    res_d          = res_q;
    res_ovf_d      = res_ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          opa_d     = op_a;
          opb_d     = op_b;
          res_ovf_d = 1'b0;
          state_d   = S_CMP;
        end
      end
      S_CMP: begin
        // 9-bit difference of sign-extended exponents cannot wrap (-255..255).
        if (add_sum[EXP_W]) begin
          larger_d       = opb_q;
          smaller_mant_d = opa_q.mant;
          diff_d         = (EXP_W+1)'(0) - add_sum[EXP_W:0];
        end else begin
          larger_d       = opa_q;
          smaller_mant_d = opb_q.mant;
          diff_d         = add_sum[EXP_W:0];
        end
        state_d = S_ALIGN;
      end
      S_ALIGN: begin
        shifted_d = (diff_q >= (EXP_W+1)'(MANT_W)) ? '0 : (smaller_mant_q >> diff_q[4:0]);
        state_d   = S_ADD;
      end
      S_ADD: begin
        sum25_d = add_sum[MANT_W:0];
        state_d = S_NORM;
      end
      S_NORM: begin
        if (sum25_q[MANT_W]) begin
          // exp+1 leaving the 8-bit signed range shows as bit 8 != bit 7.
          if (add_sum[EXP_W] != add_sum[EXP_W-1]) begin
            res_d     = SAT_POS;
            res_ovf_d = 1'b1;
          end else begin
            res_d = {add_sum[EXP_W-1:0], sum25_q[MANT_W:1]};
          end
        end else begin
          res_d = {larger_q.exp, sum25_q[MANT_W-1:0]};
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      opa_q          <= '0;
      opb_q          <= '0;
      larger_q       <= '0;
      smaller_mant_q <= '0;
      diff_q         <= '0;
      shifted_q      <= '0;
      sum25_q        <= '0;
      res_q          <= '0;
      res_ovf_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      opa_q          <= opa_d;
      opb_q          <= opb_d;
      larger_q       <= larger_d;
      smaller_mant_q <= smaller_mant_d;
      diff_q         <= diff_d;
      shifted_q      <= shifted_d;
      sum25_q        <= sum25_d;
      res_q          <= res_d;
      res_ovf_q      <= res_ovf_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign res_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign res       = res_q;
  assign res_ovf   = res_ovf_q;

endmodule
